// File: rtl/iq_rx_arbiter.sv
// Two-channel round-robin burst reader that merges IQ sample FIFOs into one stream.
// The read strobe is combinational so reads stop in the same cycle that eligibility drops.
module iq_rx_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int BURST_LEN  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_b_i,
  input  logic                    enable_i,
  input  logic [1:0]              ch_mask_i,
  input  logic                    ch0_empty_i,
  input  logic                    ch1_empty_i,
  output logic                    ch0_rd_en_o,
  output logic                    ch1_rd_en_o,
  input  logic [2*DATA_WIDTH-1:0] ch0_data_i,
  input  logic [2*DATA_WIDTH-1:0] ch1_data_i,
  output logic [2*DATA_WIDTH-1:0] out_data_o,
  output logic                    out_ch_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic                    busy_o
);

  localparam int SW = 2 * DATA_WIDTH;
  localparam logic [7:0] BURST_LEN_C = 8'(BURST_LEN);

  typedef enum logic {IDLE, BURST} state_e;

  state_e          state_q, state_d;
  logic            last_ch_q, last_ch_d;
  logic            cur_ch_q, cur_ch_d;
  logic [7:0]      burst_cnt_q, burst_cnt_d;
  logic [1:0]      occ_q, occ_d;
  logic            inflight_q, inflight_d;
  logic            inflight_ch_q, inflight_ch_d;
  logic [SW-1:0]   head_data_q, head_data_d;
  logic [SW-1:0]   tail_data_q, tail_data_d;
  logic            head_ch_q, head_ch_d;
  logic            tail_ch_q, tail_ch_d;

  logic            elig0, elig1, cur_elig, pop, issue, pick;
  logic [2:0]      level;
  logic [SW-1:0]   push_data;

  assign elig0    = enable_i & ch_mask_i[0] & ~ch0_empty_i;
  assign elig1    = enable_i & ch_mask_i[1] & ~ch1_empty_i;
  assign cur_elig = cur_ch_q ? elig1 : elig0;
  assign pop      = out_valid_o & out_ready_i;

  // Occupancy the buffer will have once every outstanding read has landed.
  assign level    = {1'b0, occ_q} - {2'b00, pop} + {2'b00, inflight_q};
  assign issue    = (state_q == BURST) & cur_elig & (burst_cnt_q < BURST_LEN_C) & (level < 3'd2);

  assign ch0_rd_en_o = issue & ~cur_ch_q;
  assign ch1_rd_en_o = issue &  cur_ch_q;
  assign push_data   = inflight_ch_q ? ch1_data_i : ch0_data_i;

  assign out_valid_o = (occ_q != 2'd0);
  assign out_data_o  = head_data_q;
  assign out_ch_o    = head_ch_q;
  assign busy_o      = (state_q == BURST) | (occ_q != 2'd0) | inflight_q;

  always_comb begin
    state_d       = state_q;
    last_ch_d     = last_ch_q;
    cur_ch_d      = cur_ch_q;
    burst_cnt_d   = burst_cnt_q;
    occ_d         = occ_q;
    inflight_d    = issue;
    inflight_ch_d = cur_ch_q;
    head_data_d   = head_data_q;
    tail_data_d   = tail_data_q;
    head_ch_d     = head_ch_q;
    tail_ch_d     = tail_ch_q;
    pick          = 1'b0;

    case (state_q)
      IDLE: begin
        if (elig0 | elig1) begin
          pick        = last_ch_q ? ~elig0 : elig1;
          state_d     = BURST;
          cur_ch_d    = pick;
          last_ch_d   = pick;
          burst_cnt_d = 8'd0;
        end
      end
      BURST: begin
        if (issue) burst_cnt_d = burst_cnt_q + 8'd1;
        if (!cur_elig || (burst_cnt_d == BURST_LEN_C)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Head is the presented sample; tail only fills when the head is stalled.
    if (pop && inflight_q) begin
      if (occ_q == 2'd1) begin
        head_data_d = push_data;
        head_ch_d   = inflight_ch_q;
      end else begin
        head_data_d = tail_data_q;
        head_ch_d   = tail_ch_q;
        tail_data_d = push_data;
        tail_ch_d   = inflight_ch_q;
      end
    end else if (pop) begin
      head_data_d = tail_data_q;
      head_ch_d   = tail_ch_q;
      occ_d       = occ_q - 2'd1;
    end else if (inflight_q) begin
      if (occ_q == 2'd0) begin
        head_data_d = push_data;
        head_ch_d   = inflight_ch_q;
      end else begin
        tail_data_d = push_data;
        tail_ch_d   = inflight_ch_q;
      end
      occ_d = occ_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_b_i) begin
    if (!rst_b_i) begin
      state_q       <= IDLE;
      last_ch_q     <= 1'b1;
      cur_ch_q      <= 1'b0;
      burst_cnt_q   <= 8'd0;
      occ_q         <= 2'd0;
      inflight_q    <= 1'b0;
      inflight_ch_q <= 1'b0;
      head_data_q   <= '0;
      tail_data_q   <= '0;
      head_ch_q     <= 1'b0;
      tail_ch_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_ch_q     <= last_ch_d;
      cur_ch_q      <= cur_ch_d;
      burst_cnt_q   <= burst_cnt_d;
      occ_q         <= occ_d;
      inflight_q    <= inflight_d;
      inflight_ch_q <= inflight_ch_d;
      head_data_q   <= head_data_d;
      tail_data_q   <= tail_data_d;
      head_ch_q     <= head_ch_d;
      tail_ch_q     <= tail_ch_d;
    end
  end

endmodule
